// File: rtl/pc_next_pkg.sv
// PC stage shared types: next-PC select codes,
// FSM state encoding and default reset PC.
package pc_next_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HALT  = 2'b01,
    ST_FAULT = 2'b10
  } state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/pc_next_unit_if.sv
// PC stage bus: control/extender inputs (PCWre, PCSrc, ExtOut,
// JumpAddr, RegTarget, Halt) and outputs (PC, PC4, Halted, AlignErr, InstCount).
interface pc_next_unit_if;
  import pc_next_pkg::*;

  logic        PCWre;
  logic [1:0]  PCSrc;
  logic [31:0] ExtOut;
  logic [25:0] JumpAddr;
  logic [31:0] RegTarget;
  logic        Halt;
  logic [31:0] PC;
  logic [31:0] PC4;
  logic        Halted;
  logic        AlignErr;
  logic [31:0] InstCount;

  modport master (
    output PCWre, PCSrc, ExtOut, JumpAddr,
    output RegTarget, Halt,
    input  PC, PC4, Halted, AlignErr, InstCount
  );

  modport slave (
    input  PCWre, PCSrc, ExtOut, JumpAddr,
    input  RegTarget, Halt,
    output PC, PC4, Halted, AlignErr, InstCount
  );

endinterface

// File: rtl/pc_target_mux.sv
// Combinational next-PC selector. In: pc4_i, ext_i, jaddr_i, rtgt_i,
// src_i. Out: tgt_o (selected target), mis_o (target[1:0] != 0).
module pc_target_mux
  import pc_next_pkg::*;
(
  input  logic [31:0] pc4_i,
  input  logic [31:0] ext_i,
  input  logic [25:0] jaddr_i,
  input  logic [31:0] rtgt_i,
  input  logic [1:0]  src_i,
  output logic [31:0] tgt_o,
  output logic        mis_o
);

  logic [31:0] br_off;

  // Shift drops ExtOut[31:30]; sign already lives in bit 29 and up.
  assign br_off = ext_i << 2;

  always_comb begin
    tgt_o = pc4_i;
    unique case (src_i)
      PCSRC_SEQ: tgt_o = pc4_i;
      PCSRC_BR:  tgt_o = pc4_i + br_off;
      PCSRC_JR:  tgt_o = rtgt_i;
      PCSRC_J:   tgt_o = {pc4_i[31:28], jaddr_i, 2'b00};
      default:   tgt_o = pc4_i;
    endcase
  end

  assign mis_o = |tgt_o[1:0];

endmodule

// File: rtl/pc_next_unit.sv
// PC register, instruction counter and run/halt/fault FSM.
// Ports: CLK, Reset (sync, active high), bus (slave modport).
module pc_next_unit
  import pc_next_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic    CLK,
  input  logic    Reset,
  pc_next_unit_if.slave bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  state_e      st_q, st_d;
  logic        halted_q, halted_d;
  logic        aerr_q, aerr_d;
  logic [31:0] pc4;
  logic [31:0] tgt;
  logic        mis;

  assign pc4 = pc_q + 32'd4;

  pc_target_mux u_mux (
    .pc4_i   (pc4),
    .ext_i   (bus.ExtOut),
    .jaddr_i (bus.JumpAddr),
    .rtgt_i  (bus.RegTarget),
    .src_i   (bus.PCSrc),
    .tgt_o   (tgt),
    .mis_o   (mis)
  );

  // HALT/FAULT fall through to hold: only Reset leaves them.
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    st_d  = st_q;
    if (st_q == ST_RUN && bus.PCWre) begin
      if (bus.Halt) begin
        st_d = ST_HALT;
      end else if (mis) begin
        st_d = ST_FAULT;
      end else begin
        pc_d  = tgt;
        cnt_d = cnt_q + 32'd1;
      end
    end
    halted_d = (st_d == ST_HALT);
    aerr_d   = (st_d == ST_FAULT);
  end

  // Flags are registered so they rise cleanly with the state.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      st_q     <= ST_RUN;
      halted_q <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      st_q     <= st_d;
      halted_q <= halted_d;
      aerr_q   <= aerr_d;
    end
  end

  assign bus.PC        = pc_q;
  assign bus.PC4       = pc4;
  assign bus.Halted    = halted_q;
  assign bus.AlignErr  = aerr_q;
  assign bus.InstCount = cnt_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: directed plan
// sequences then random traffic against a reference model.
module tb_pc_next_unit;
  import pc_next_pkg::*;

  logic CLK = 1'b0;
  logic Reset;

  pc_next_unit_if bus ();

  pc_next_unit dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        h;
    logic        a;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  int          m_mode; // 0 run, 1 halted, 2 fault

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_target(
    input logic [31:0] pc, input logic [1:0] src,
    input logic [31:0] ext, input logic [25:0] ja,
    input logic [31:0] rt);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    case (src)
      2'd0: return p4;
      2'd1: return p4 + ext * 32'd4;
      2'd2: return rt;
      default: return (p4 & 32'hF000_0000) | ({6'd0, ja} * 32'd4);
    endcase
  endfunction

  task automatic drive(input logic rst, input logic we,
                       input logic [1:0] src,
                       input logic [31:0] ext,
                       input logic [25:0] ja,
                       input logic [31:0] rt,
                       input logic h);
    logic [31:0] t;
    exp_t e;
    @(negedge CLK);
    Reset         = rst;
    bus.PCWre     = we;
    bus.PCSrc     = src;
    bus.ExtOut    = ext;
    bus.JumpAddr  = ja;
    bus.RegTarget = rt;
    bus.Halt      = h;
    if (rst) begin
      m_pc = 32'h0; m_cnt = 32'h0; m_mode = 0;
    end else if (m_mode == 0 && we) begin
      if (h) m_mode = 1;
      else begin
        t = ref_target(m_pc, src, ext, ja, rt);
        if (t % 4 != 0) m_mode = 2;
        else begin
          m_pc = t;
          m_cnt = m_cnt + 32'd1;
        end
      end
    end
    e.pc = m_pc; e.cnt = m_cnt;
    e.h = (m_mode == 1); e.a = (m_mode == 2);
    q.push_back(e);
  endtask

  task automatic idle(input logic we, input logic [1:0] src);
    drive(1'b0, we, src, 32'h0, 26'h0, 32'h0, 1'b0);
  endtask

  task automatic jr(input logic [31:0] rt);
    drive(1'b0, 1'b1, PCSRC_JR, 32'h0, 26'h0, rt, 1'b0);
  endtask

  // Absolute checks anchored to hand-computed plan values.
  task automatic anchor(input string n, input logic [31:0] pc);
    @(posedge CLK); #2;
    chk(n, bus.PC, pc);
  endtask

  // Monitor: compare the registered state right after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", bus.PC, e.pc);
        chk("pc4", bus.PC4, e.pc + 32'd4);
        chk("icount", bus.InstCount, e.cnt);
        chk("halted", {31'd0, bus.Halted}, {31'd0, e.h});
        chk("alignerr", {31'd0, bus.AlignErr}, {31'd0, e.a});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    Reset = 1'b1;
    bus.PCWre = 0; bus.PCSrc = 0; bus.ExtOut = 0;
    bus.JumpAddr = 0; bus.RegTarget = 0; bus.Halt = 0;
    m_pc = 0; m_cnt = 0; m_mode = 0;

    drive(1'b1, 1'b1, PCSRC_SEQ, 0, 0, 0, 0);
    drive(1'b1, 1'b0, PCSRC_SEQ, 0, 0, 0, 0);
    repeat (3) idle(1'b1, PCSRC_SEQ);
    anchor("seq3", 32'hC);

    jr(32'h40);
    drive(1'b0, 1'b1, PCSRC_BR, 32'hFFFF_FFFE, 0, 0, 0);
    anchor("br_neg", 32'h3C);
    drive(1'b0, 1'b1, PCSRC_BR, 32'h10, 0, 0, 0);
    anchor("br_pos", 32'h80);

    jr(32'h1000_0000);
    drive(1'b0, 1'b1, PCSRC_J, 0, 26'h100, 0, 0);
    anchor("jump", 32'h1000_0400);
    jr(32'h200);
    anchor("jr", 32'h200);

    jr(32'h202);
    anchor("fault_hold", 32'h200);
    idle(1'b1, PCSRC_SEQ);
    jr(32'h400);
    drive(1'b0, 1'b1, PCSRC_J, 0, 26'h3, 0, 1'b1);
    drive(1'b1, 1'b0, PCSRC_SEQ, 0, 0, 0, 0);
    anchor("fault_reset", 32'h0);

    idle(1'b1, PCSRC_SEQ);
    drive(1'b0, 1'b0, PCSRC_SEQ, 0, 0, 0, 1'b1);
    drive(1'b0, 1'b1, PCSRC_SEQ, 0, 0, 0, 1'b1);
    anchor("halt_hold", 32'h4);
    idle(1'b1, PCSRC_SEQ);
    jr(32'h100);
    drive(1'b1, 1'b1, PCSRC_SEQ, 0, 0, 0, 0);
    idle(1'b1, PCSRC_SEQ);

    jr(32'hFFFF_FFFC);
    idle(1'b1, PCSRC_SEQ);
    anchor("wrap", 32'h0);
    repeat (4) idle(1'b0, PCSRC_J);

    for (int i = 0; i < 500; i++) begin
      logic rst, we, h;
      logic [1:0] src;
      logic [31:0] ext, rt;
      logic [25:0] ja;
      rst = ($urandom % 30 == 0);
      we  = ($urandom % 4 != 0);
      h   = ($urandom % 40 == 0);
      src = 2'($urandom % 4);
      ext = $urandom;
      r   = $urandom;
      ja  = r[25:0];
      rt  = $urandom & 32'hFFFF_FFFC;
      if ($urandom % 8 == 0) rt[1:0] = 2'($urandom % 4);
      drive(rst, we, src, ext, ja, rt, h);
    end

    repeat (3) @(posedge CLK);
    #2;
    chk("drain", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Program-counter stage of the single-cycle CPU. It holds the PC, computes the next PC, and supplies PC and PC+4 to instruction memory and the register-write path. It sits directly downstream of the sign/zero extender, consuming its 32-bit output as the branch offset. A small run/halt/fault state machine freezes fetch on a halt instruction or on a misaligned register jump target.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- PCWre  input  1  PC write enable from the control unit; 0 = stall, PC holds.
- PCSrc  input  2  next-PC select:
  - 00: PC+4.
  - 01: branch, PC+4+(ExtOut<<2).
  - 10: register jump, RegTarget.
  - 11: jump, {PC4[31:28], JumpAddr, 2'b00}.
- ExtOut  input  32  sign/zero-extended immediate from the extender.
- JumpAddr  input  26  instruction[25:0].
- RegTarget  input  32  rs read data for jr.
- Halt  input  1  halt instruction decoded in the current cycle.
- PC  output  32  current PC; reset value RESET_PC.
- PC4  output  32  PC+4, combinational; reset value RESET_PC+4.
- Halted  output  1  1 in state HALT; reset value 0.
- AlignErr  output  1  1 in state FAULT (sticky until Reset); reset value 0.
- InstCount  output  32  number of committed PC updates; reset value 0.

## Operation
- State machine, encoded in 2 bits:
  - RUN (reset state).
  - HALT.
  - FAULT.
- A commit is a cycle in which state = RUN, PCWre = 1, Halt = 0, and the selected target is aligned.
- On a commit: PC ← selected target, InstCount ← InstCount+1, state stays RUN.
- RUN & PCWre & Halt: PC holds, state → HALT. InstCount does not increment. The alignment check is ignored.
- RUN & PCWre & !Halt & target[1:0] != 0: PC holds, state → FAULT. Only PCSrc=10 can produce this.
- RUN & !PCWre: PC, InstCount and state all hold. Halt and misalignment are ignored while stalled.
- HALT and FAULT: PC and InstCount are frozen. Both states are left only by Reset.
- Arithmetic:
  - All arithmetic is modulo 2^32.
  - The branch offset is {ExtOut[29:0], 2'b00}, added to PC4. Sign comes from ExtOut; no further extension.
  - PC at 32'hFFFF_FFFC with PCSrc=00 wraps to 32'h0000_0000.
  - InstCount wraps from 32'hFFFF_FFFF to 0.
- Reset has priority over all inputs. Reset in any state, including mid-HALT or mid-FAULT, returns to RUN with PC=RESET_PC and InstCount=0.

## Timing
- PC, state and InstCount are registered and update on the same rising edge. There is exactly one cycle from the inputs to the new PC.
- PC4 and the next-PC mux are purely combinational from the current PC and inputs, with zero latency.
- Halted and AlignErr are decoded from registered state. Each rises in the cycle after the triggering edge, with no glitch.
- When Reset and PCWre are asserted in the same cycle, Reset wins.
- The first committed instruction after Reset release is fetched at RESET_PC in the release cycle.

## Structure
- Package pc_next_pkg holds:
  - PCSrc encodings: PCSRC_SEQ, PCSRC_BR, PCSRC_JR, PCSRC_J.
  - State encodings: ST_RUN, ST_HALT, ST_FAULT.
  - The default RESET_PC constant.
- Sub-module pc_target_mux is combinational. It takes PC4, ExtOut, JumpAddr, RegTarget and PCSrc, and produces the 32-bit target and a misaligned flag.
- The top level holds only the registers and the FSM.

## Test plan
- Reset, then 3 cycles with PCWre=1, PCSrc=00: PC goes 0→4→8→C, InstCount=3, PC4=0x10.
- PC=0x40, PCSrc=01, ExtOut=32'hFFFF_FFFE: next PC=0x3C. Then ExtOut=0x10: next PC=0x80.
- PC=0x1000_0000, PCSrc=11, JumpAddr=26'h0000_100: next PC=0x1000_0400. Then PCSrc=10 with RegTarget=0x200: PC=0x200.
- PCSrc=10, RegTarget=0x202: PC holds and AlignErr=1 the next cycle. Further PCWre/PCSrc activity has no effect. Reset clears AlignErr and sets PC=0.
- Halt=1 with PCWre=0: no effect. Halt=1 with PCWre=1: PC holds, Halted=1 next cycle, InstCount frozen. Reset mid-HALT: RUN, PC=0.
- PC forced to 0xFFFF_FFFC via jr: PCSrc=00 wraps PC to 0. PCWre=0 for 4 cycles: PC and InstCount unchanged.
